// File: rtl/ofifo.sv
// Output-side row collector for the MAC array: one FIFO per column, skewed
// column writes are re-aligned and popped one complete row at a time.
module ofifo #(
    parameter int col     = 8,
    parameter int bw_psum = 12,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*bw_psum-1:0] in,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_rd_ack,
    output logic                   o_overflow
);

    localparam int pw = $clog2(depth);
    localparam int ow = pw + 1;
    localparam logic [ow-1:0] occ_max = ow'(depth);

    logic [bw_psum-1:0] mem    [col][depth];
    logic [pw-1:0]      wr_ptr [col];
    logic [pw-1:0]      rd_ptr [col];
    logic [ow-1:0]      occ    [col];

    logic [col-1:0] lane_nonempty;
    logic [col-1:0] lane_full;
    logic [col-1:0] wr_acc;
    logic [col-1:0] wr_drop;
    logic           pop;

    always_comb begin
        lane_nonempty = '0;
        lane_full     = '0;
        for (int k = 0; k < col; k++) begin
            lane_nonempty[k] = (occ[k] != '0);
            lane_full[k]     = (occ[k] == occ_max);
        end
    end

    // Handshake: o_valid means every lane holds a head entry; a pop is taken
    // on any edge where rd=1 and o_valid=1, and o_rd_ack marks the new row on out.
    assign o_valid = &lane_nonempty;
    assign o_full  = |lane_full;
    assign pop     = rd && o_valid;

    // A full lane still takes a write when the shared pop frees a slot this edge.
    always_comb begin
        wr_acc  = '0;
        wr_drop = '0;
        for (int k = 0; k < col; k++) begin
            wr_acc[k]  = wr[k] && (!lane_full[k] || pop);
            wr_drop[k] = wr[k] && lane_full[k] && !pop;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < col; k++) begin
            if (wr_acc[k]) begin
                mem[k][wr_ptr[k]] <= in[k*bw_psum +: bw_psum];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < col; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                occ[k]    <= '0;
            end
            out        <= '0;
            o_rd_ack   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_rd_ack <= pop;
            if (|wr_drop) begin
                o_overflow <= 1'b1;
            end
            for (int k = 0; k < col; k++) begin
                if (wr_acc[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + 1'b1;
                end
                if (pop) begin
                    rd_ptr[k]                    <= rd_ptr[k] + 1'b1;
                    out[k*bw_psum +: bw_psum]    <= mem[k][rd_ptr[k]];
                end
                case ({wr_acc[k], pop})
                    2'b10:   occ[k] <= occ[k] + 1'b1;
                    2'b01:   occ[k] <= occ[k] - 1'b1;
                    default: occ[k] <= occ[k];
                endcase
            end
        end
    end

endmodule
